// File: rtl/dna_job_scheduler_if.sv
// Request, response and controller signals shared between the DNA job scheduler and its
// environment. The slave modport is the scheduler side.
interface dna_job_scheduler_if #(
    parameter int unsigned MSG_W = 39,
    parameter int unsigned DNA_W = 320
);
    logic             wr_req_valid;
    logic             wr_req_ready;
    logic [MSG_W-1:0] wr_req_msg;
    logic             rd_req_valid;
    logic             rd_req_ready;
    logic [DNA_W-1:0] rd_req_dna;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_is_read;
    logic             resp_err;
    logic [MSG_W-1:0] resp_msg;
    logic [DNA_W-1:0] resp_dna;
    logic [1:0]       ctrl_mode;
    logic [MSG_W-1:0] ctrl_write_in;
    logic [DNA_W-1:0] ctrl_read_in;
    logic [DNA_W-1:0] ctrl_write_out;
    logic [MSG_W-1:0] ctrl_read_out;
    logic             ctrl_finish;
    logic             ctrl_rst_n;
    logic             busy;
    logic [15:0]      ok_count;
    logic [15:0]      err_count;

    modport slave (
        input  wr_req_valid, wr_req_msg, rd_req_valid, rd_req_dna, resp_ready,
               ctrl_write_out, ctrl_read_out, ctrl_finish,
        output wr_req_ready, rd_req_ready, resp_valid, resp_is_read, resp_err, resp_msg,
               resp_dna, ctrl_mode, ctrl_write_in, ctrl_read_in, ctrl_rst_n, busy,
               ok_count, err_count
    );

    modport master (
        output wr_req_valid, wr_req_msg, rd_req_valid, rd_req_dna, resp_ready,
               ctrl_write_out, ctrl_read_out, ctrl_finish,
        input  wr_req_ready, rd_req_ready, resp_valid, resp_is_read, resp_err, resp_msg,
               resp_dna, ctrl_mode, ctrl_write_in, ctrl_read_in, ctrl_rst_n, busy,
               ok_count, err_count
    );
endinterface

// File: rtl/dna_job_scheduler.sv
// Round-robin scheduler sharing one DNA storage controller between write (encode) and read
// (decode) request channels, with a watchdog that times out and resets a stuck controller.
module dna_job_scheduler #(
    parameter int unsigned MSG_W       = 39,
    parameter int unsigned DNA_W       = 320,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned RST_CYC     = 2
) (
    input logic                 clk,
    input logic                 resetN,
    dna_job_scheduler_if.slave  bus
);

    localparam int unsigned CntMax = (TIMEOUT_CYC > RST_CYC) ? TIMEOUT_CYC : RST_CYC;
    localparam int unsigned CntW   = $clog2(CntMax) + 1;
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYC - 1);
    localparam logic [CntW-1:0] RstLast     = CntW'(RST_CYC - 1);
    localparam logic [CntW-1:0] CntOne      = CntW'(1);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StRecover} state_e;

    state_e           state_q, state_d;
    logic             last_rd_q, last_rd_d;
    logic             job_rd_q, job_rd_d;
    logic [MSG_W-1:0] wr_op_q, wr_op_d;
    logic [DNA_W-1:0] rd_op_q, rd_op_d;
    logic [MSG_W-1:0] resp_msg_q, resp_msg_d;
    logic [DNA_W-1:0] resp_dna_q, resp_dna_d;
    logic             resp_err_q, resp_err_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [15:0]      ok_cnt_q, ok_cnt_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic             grant_wr, grant_rd;

    // On a tie the channel that did not win last time gets the grant.
    assign grant_wr = bus.wr_req_valid & (~bus.rd_req_valid | last_rd_q);
    assign grant_rd = bus.rd_req_valid & (~bus.wr_req_valid | ~last_rd_q);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= StIdle;
            last_rd_q  <= 1'b1;
            job_rd_q   <= 1'b0;
            wr_op_q    <= '0;
            rd_op_q    <= '0;
            resp_msg_q <= '0;
            resp_dna_q <= '0;
            resp_err_q <= 1'b0;
            cnt_q      <= '0;
            ok_cnt_q   <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_rd_q  <= last_rd_d;
            job_rd_q   <= job_rd_d;
            wr_op_q    <= wr_op_d;
            rd_op_q    <= rd_op_d;
            resp_msg_q <= resp_msg_d;
            resp_dna_q <= resp_dna_d;
            resp_err_q <= resp_err_d;
            cnt_q      <= cnt_d;
            ok_cnt_q   <= ok_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_rd_d  = last_rd_q;
        job_rd_d   = job_rd_q;
        wr_op_d    = wr_op_q;
        rd_op_d    = rd_op_q;
        resp_msg_d = resp_msg_q;
        resp_dna_d = resp_dna_q;
        resp_err_d = resp_err_q;
        cnt_d      = cnt_q;
        ok_cnt_d   = ok_cnt_q;
        err_cnt_d  = err_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (grant_wr) begin
                    wr_op_d   = bus.wr_req_msg;
                    job_rd_d  = 1'b0;
                    last_rd_d = 1'b0;
                    state_d   = StIssue;
                end else if (grant_rd) begin
                    rd_op_d   = bus.rd_req_dna;
                    job_rd_d  = 1'b1;
                    last_rd_d = 1'b1;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // A finish left high from the previous job is ignored in the first cycle.
                if (bus.ctrl_finish && (cnt_q != '0)) begin
                    resp_err_d = 1'b0;
                    resp_msg_d = job_rd_q ? bus.ctrl_read_out : '0;
                    resp_dna_d = job_rd_q ? '0 : bus.ctrl_write_out;
                    ok_cnt_d   = (ok_cnt_q == 16'hFFFF) ? ok_cnt_q : ok_cnt_q + 16'd1;
                    state_d    = StResp;
                end else if (cnt_q == TimeoutLast) begin
                    resp_err_d = 1'b1;
                    resp_msg_d = '0;
                    resp_dna_d = '0;
                    err_cnt_d  = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
                    cnt_d      = '0;
                    state_d    = StRecover;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StRecover: begin
                if (cnt_q == RstLast) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StResp: begin
                if (bus.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.wr_req_ready  = (state_q == StIdle) & grant_wr;
        bus.rd_req_ready  = (state_q == StIdle) & grant_rd;
        bus.ctrl_mode     = (state_q == StIssue) ? (job_rd_q ? 2'd2 : 2'd1) : 2'd0;
        bus.ctrl_rst_n    = (state_q != StRecover);
        bus.resp_valid    = (state_q == StResp);
        bus.busy          = (state_q != StIdle);
        bus.resp_is_read  = job_rd_q;
        bus.resp_err      = resp_err_q;
        bus.resp_msg      = resp_msg_q;
        bus.resp_dna      = resp_dna_q;
        bus.ctrl_write_in = wr_op_q;
        bus.ctrl_read_in  = rd_op_q;
        bus.ok_count      = ok_cnt_q;
        bus.err_count     = err_cnt_q;
    end

endmodule
